// File: rtl/ysyx_23060191_csr_file.sv
// Machine-mode CSR file for a single-hart RV32/RV64 core.
//
// Implements mstatus (MIE/MPIE only, MPP hard-wired to M), mtvec, mscratch, mepc,
// mcause, mvendorid, marchid and, optionally, the 64-bit mcycle/minstret counters.
// Trap entry and mret update mstatus/mepc/mcause directly, taking priority over a
// software CSR write issued in the same cycle.
//
// Ports:
//   clk, rst        - clock (rising edge) and asynchronous active-high reset
//   csr_en          - CSR instruction valid this cycle
//   csr_op          - 00 read, 01 write, 10 set bits, 11 clear bits
//   csr_addr        - CSR address
//   csr_wdata       - operand (rs1 or zimm)
//   csr_rdata       - current (pre-edge) value of csr_addr, combinational
//   csr_illegal     - unimplemented address, or write to a read-only CSR
//   trap_en/pc/cause- trap entry request with faulting PC and cause code
//   mret_en         - mret executes
//   retire          - one instruction retired this cycle
//   mtvec, mepc     - registered trap vector and return PC
//   mstatus_mie     - registered global interrupt enable
module ysyx_23060191_csr_file #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     HAS_COUNTERS = 1,
    parameter logic [XLEN-1:0] MVENDORID    = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_en,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic            mret_en,
    input  logic            retire,
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mepc,
    output logic            mstatus_mie
);

    localparam logic [11:0] AddrMstatus   = 12'h300;
    localparam logic [11:0] AddrMtvec     = 12'h305;
    localparam logic [11:0] AddrMscratch  = 12'h340;
    localparam logic [11:0] AddrMepc      = 12'h341;
    localparam logic [11:0] AddrMcause    = 12'h342;
    localparam logic [11:0] AddrMvendorid = 12'hF11;
    localparam logic [11:0] AddrMarchid   = 12'hF12;
    localparam logic [11:0] AddrMcycle    = 12'hB00;
    localparam logic [11:0] AddrMinstret  = 12'hB02;
    localparam logic [11:0] AddrMcycleh   = 12'hB80;
    localparam logic [11:0] AddrMinstreth = 12'hB82;

    localparam bit HasCnt = (HAS_COUNTERS != 0);
    // Upper-half counter aliases only exist on RV32.
    localparam bit HasHi  = HasCnt && (XLEN == 32);

    // Clears bits [1:0]: mtvec is direct-mode only and mepc is always aligned.
    localparam logic [XLEN-1:0] AlignMask = {{(XLEN-2){1'b1}}, 2'b00};

    localparam logic [1:0] OpRead  = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpSet   = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [63:0]     mcycle_q, mcycle_d;
    logic [63:0]     minstret_q, minstret_d;

    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] rdata;
    logic            addr_ok;
    logic            addr_ro;
    logic            is_write;
    logic            wr_en;
    logic [XLEN-1:0] wval;

    // Read mux and address decode.
    always_comb begin
        rdata       = '0;
        addr_ok     = 1'b0;
        addr_ro     = 1'b0;
        mstatus_val = '0;
        mstatus_val[12:11] = 2'b11;
        mstatus_val[7]     = mpie_q;
        mstatus_val[3]     = mie_q;
        case (csr_addr)
            AddrMstatus:   begin addr_ok = 1'b1; rdata = mstatus_val; end
            AddrMtvec:     begin addr_ok = 1'b1; rdata = mtvec_q;     end
            AddrMscratch:  begin addr_ok = 1'b1; rdata = mscratch_q;  end
            AddrMepc:      begin addr_ok = 1'b1; rdata = mepc_q;      end
            AddrMcause:    begin addr_ok = 1'b1; rdata = mcause_q;    end
            AddrMvendorid: begin addr_ok = 1'b1; addr_ro = 1'b1; rdata = MVENDORID; end
            AddrMarchid:   begin addr_ok = 1'b1; addr_ro = 1'b1; end
            AddrMcycle: begin
                if (HasCnt) begin
                    addr_ok = 1'b1;
                    rdata   = mcycle_q[XLEN-1:0];
                end
            end
            AddrMinstret: begin
                if (HasCnt) begin
                    addr_ok = 1'b1;
                    rdata   = minstret_q[XLEN-1:0];
                end
            end
            AddrMcycleh: begin
                if (HasHi) begin
                    addr_ok = 1'b1;
                    rdata   = XLEN'(mcycle_q[63:32]);
                end
            end
            AddrMinstreth: begin
                if (HasHi) begin
                    addr_ok = 1'b1;
                    rdata   = XLEN'(minstret_q[63:32]);
                end
            end
            default: ;
        endcase
    end

    // Set/clear with a zero operand is a pure read and never faults on RO CSRs.
    always_comb begin
        is_write = 1'b0;
        wval     = rdata;
        case (csr_op)
            OpWrite: begin is_write = 1'b1;              wval = csr_wdata;          end
            OpSet:   begin is_write = (csr_wdata != '0); wval = rdata | csr_wdata;  end
            OpClear: begin is_write = (csr_wdata != '0); wval = rdata & ~csr_wdata; end
            OpRead:  ;
            default: ;
        endcase
    end

    assign csr_illegal = csr_en && (!addr_ok || (is_write && addr_ro));
    assign wr_en       = csr_en && is_write && !csr_illegal;
    assign csr_rdata   = rdata;

    // Next state: software write, then mret, then trap; later assignments win.
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, retire};

        if (wr_en) begin
            case (csr_addr)
                AddrMstatus: begin
                    mie_d  = wval[3];
                    mpie_d = wval[7];
                end
                AddrMtvec:    mtvec_d    = wval & AlignMask;
                AddrMscratch: mscratch_d = wval;
                AddrMepc:     mepc_d     = wval & AlignMask;
                AddrMcause:   mcause_d   = wval;
                AddrMcycle: begin
                    if (XLEN == 32) mcycle_d = {mcycle_q[63:32], wval[31:0]};
                    else            mcycle_d = 64'(wval);
                end
                AddrMinstret: begin
                    if (XLEN == 32) minstret_d = {minstret_q[63:32], wval[31:0]};
                    else            minstret_d = 64'(wval);
                end
                AddrMcycleh:   mcycle_d   = {wval[31:0], mcycle_q[31:0]};
                AddrMinstreth: minstret_d = {wval[31:0], minstret_q[31:0]};
                default: ;
            endcase
        end

        if (mret_en) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end

        if (trap_en) begin
            mepc_d   = trap_pc & AlignMask;
            mcause_d = trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end

        if (!HasCnt) begin
            mcycle_d   = '0;
            minstret_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign mtvec       = mtvec_q;
    assign mepc        = mepc_q;
    assign mstatus_mie = mie_q;

endmodule

// File: tb/tb_ysyx_23060191_csr_file.sv
// Directed self-checking bench for ysyx_23060191_csr_file (XLEN=32, counters on).
// Inputs change 1 time unit after a rising edge; outputs are sampled mid-cycle.
module tb_ysyx_23060191_csr_file;

    logic        clk;
    logic        rst;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_en;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic        mret_en;
    logic        retire;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        mstatus_mie;

    int n_vec;
    int n_err;

    ysyx_23060191_csr_file #(
        .XLEN         (32),
        .HAS_COUNTERS (1),
        .MVENDORID    (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .csr_en      (csr_en),
        .csr_op      (csr_op),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .trap_en     (trap_en),
        .trap_pc     (trap_pc),
        .trap_cause  (trap_cause),
        .mret_en     (mret_en),
        .retire      (retire),
        .mtvec       (mtvec),
        .mepc        (mepc),
        .mstatus_mie (mstatus_mie)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a CSR instruction and let the combinational outputs settle.
    task automatic drive(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
        csr_en    = 1'b1;
        csr_op    = op;
        csr_addr  = addr;
        csr_wdata = wd;
        #1;
    endtask

    // Passive read: no instruction, just look at csr_rdata for addr.
    task automatic rd(input logic [11:0] addr);
        csr_en   = 1'b0;
        csr_op   = 2'b00;
        csr_addr = addr;
        #1;
    endtask

    // One rising edge, then drop all single-cycle strobes.
    task automatic step();
        @(posedge clk);
        #1;
        csr_en  = 1'b0;
        trap_en = 1'b0;
        mret_en = 1'b0;
        retire  = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        csr_en = 1'b0; csr_op = 2'b00; csr_addr = 12'h0; csr_wdata = 32'h0;
        trap_en = 1'b0; trap_pc = 32'h0; trap_cause = 32'h0;
        mret_en = 1'b0; retire = 1'b0;

        // Reset state and free-running mcycle.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rd(12'h300); chk("rst_mstatus", csr_rdata, 32'h0000_1800);
        chk("rst_mtvec", mtvec, 32'h0);
        chk("rst_mepc", mepc, 32'h0);
        chk("rst_mie", {31'd0, mstatus_mie}, 32'h0);
        rd(12'hB00); chk("rst_mcycle", csr_rdata, 32'h0);
        repeat (5) @(posedge clk);
        #1;
        rd(12'hB00); chk("mcycle_5", csr_rdata, 32'd5);

        // RW / RS / RC basics.
        drive(2'b01, 12'h305, 32'h8000_0103);
        chk("mtvec_wr_legal", {31'd0, csr_illegal}, 32'h0);
        step();
        chk("mtvec_aligned", mtvec, 32'h8000_0100);
        drive(2'b10, 12'h300, 32'h8);
        chk("rs_pre_edge_read", csr_rdata, 32'h0000_1800);
        step();
        chk("rs_mie", {31'd0, mstatus_mie}, 32'h1);
        rd(12'h300); chk("rs_mstatus", csr_rdata, 32'h0000_1808);
        drive(2'b11, 12'h300, 32'h8);
        step();
        rd(12'h300); chk("rc_mstatus", csr_rdata, 32'h0000_1800);
        drive(2'b01, 12'h300, 32'hFFFF_FFFF);
        step();
        rd(12'h300); chk("mstatus_wmask", csr_rdata, 32'h0000_1888);
        drive(2'b01, 12'h300, 32'h8);
        step();
        rd(12'h300); chk("mstatus_mie_only", csr_rdata, 32'h0000_1808);

        // Trap entry and mret.
        trap_en = 1'b1; trap_pc = 32'h8000_0010; trap_cause = 32'd11;
        step();
        chk("trap_mepc", mepc, 32'h8000_0010);
        rd(12'h342); chk("trap_mcause", csr_rdata, 32'd11);
        rd(12'h300); chk("trap_mstatus", csr_rdata, 32'h0000_1880);
        mret_en = 1'b1;
        step();
        rd(12'h300); chk("mret_mstatus", csr_rdata, 32'h0000_1888);
        chk("mret_mie", {31'd0, mstatus_mie}, 32'h1);

        // Trap beats a same-cycle mepc write; unaligned trap_pc is aligned.
        drive(2'b01, 12'h341, 32'h0000_1234);
        trap_en = 1'b1; trap_pc = 32'h8000_0013; trap_cause = 32'd7;
        step();
        chk("trap_vs_mepc_wr", mepc, 32'h8000_0010);
        rd(12'h300); chk("trap2_mstatus", csr_rdata, 32'h0000_1880);
        // Non-overlapping mscratch write still lands during a trap.
        drive(2'b01, 12'h340, 32'hCAFE_BABE);
        trap_en = 1'b1; trap_pc = 32'h0000_0400; trap_cause = 32'd2;
        step();
        rd(12'h340); chk("trap_mscratch", csr_rdata, 32'hCAFE_BABE);
        chk("trap3_mepc", mepc, 32'h0000_0400);
        rd(12'h342); chk("trap3_mcause", csr_rdata, 32'd2);
        chk("trap3_mtvec_kept", mtvec, 32'h8000_0100);
        // mret beats a same-cycle mstatus write.
        drive(2'b01, 12'h300, 32'hFFFF_FFFF);
        mret_en = 1'b1;
        step();
        rd(12'h300); chk("mret_vs_wr", csr_rdata, 32'h0000_1880);
        drive(2'b01, 12'h341, 32'h0000_1237);
        step();
        chk("mepc_aligned", mepc, 32'h0000_1234);

        // mcycle low-to-high carry.
        drive(2'b01, 12'hB00, 32'hFFFF_FFFF);
        step();
        drive(2'b01, 12'hB80, 32'h0);
        step();
        rd(12'hB00); chk("mcycle_wr_lo", csr_rdata, 32'hFFFF_FFFF);
        rd(12'hB80); chk("mcycle_wr_hi", csr_rdata, 32'h0);
        step();
        rd(12'hB00); chk("mcycle_carry_lo", csr_rdata, 32'h0);
        rd(12'hB80); chk("mcycle_carry_hi", csr_rdata, 32'h1);
        step();
        rd(12'hB00); chk("mcycle_resume", csr_rdata, 32'h1);
        // 64-bit wrap.
        drive(2'b01, 12'hB00, 32'hFFFF_FFFF);
        step();
        drive(2'b01, 12'hB80, 32'hFFFF_FFFF);
        step();
        step();
        rd(12'hB00); chk("mcycle_wrap_lo", csr_rdata, 32'h0);
        rd(12'hB80); chk("mcycle_wrap_hi", csr_rdata, 32'h0);

        // minstret counts only retire pulses.
        drive(2'b01, 12'hB02, 32'h0);
        step();
        drive(2'b01, 12'hB82, 32'h0);
        step();
        retire = 1'b1; step();
        retire = 1'b1; step();
        step();
        retire = 1'b1; step();
        step();
        rd(12'hB02); chk("minstret_3", csr_rdata, 32'd3);
        rd(12'hB82); chk("minstreth_0", csr_rdata, 32'd0);
        drive(2'b01, 12'hB02, 32'h10);
        retire = 1'b1;
        step();
        rd(12'hB02); chk("minstret_wr_wins", csr_rdata, 32'h10);
        retire = 1'b1;
        step();
        rd(12'hB02); chk("minstret_resume", csr_rdata, 32'h11);

        // Illegal accesses.
        drive(2'b01, 12'hF11, 32'h5);
        chk("ro_write_illegal", {31'd0, csr_illegal}, 32'h1);
        chk("mvendorid_val", csr_rdata, 32'h0);
        step();
        rd(12'hF11); chk("ro_unchanged", csr_rdata, 32'h0);
        drive(2'b00, 12'h7C0, 32'h0);
        chk("unimpl_illegal", {31'd0, csr_illegal}, 32'h1);
        chk("unimpl_reads_0", csr_rdata, 32'h0);
        drive(2'b01, 12'h7C0, 32'hFFFF_FFFF);
        step();
        chk("unimpl_no_effect", mtvec, 32'h8000_0100);
        drive(2'b10, 12'hF11, 32'h0);
        chk("rs0_ro_legal", {31'd0, csr_illegal}, 32'h0);
        drive(2'b00, 12'hF12, 32'h0);
        chk("marchid_read_legal", {31'd0, csr_illegal}, 32'h0);
        drive(2'b11, 12'hF12, 32'h1);
        chk("rc_ro_illegal", {31'd0, csr_illegal}, 32'h1);
        rd(12'h7C0); chk("no_en_no_illegal", {31'd0, csr_illegal}, 32'h0);
        step();

        // Asynchronous reset in the middle of a pending write.
        drive(2'b01, 12'h340, 32'h0000_0055);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_mscratch", csr_rdata, 32'h0);
        chk("async_rst_mtvec", mtvec, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        csr_en = 1'b0;
        rd(12'h340); chk("rst_discard_wr", csr_rdata, 32'h0);
        rd(12'hB00); chk("rst_mcycle_0", csr_rdata, 32'h0);
        step();
        rd(12'hB00); chk("rst_first_inc", csr_rdata, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
